// File: rtl/lane_collector.sv
// ---------------------------------------------------------------------------
// lane_collector
//
// Gathers LANES lanes of W bits each, one per accepted transfer, into a single
// registered state vector. After the final lane arrives, the state is
// presented with state_valid and held until the consumer acknowledges it.
//
// Parameters:
//   W      lane width in bits (default 64)
//   LANES  lanes per state (default 25)
//
// Ports:
//   clk          single clock; all state changes happen on its rising edge
//   rst          asynchronous, active-low reset
//   start        begin collecting one state (sampled only while idle)
//   lane_valid   lane_data carries a valid lane
//   lane_data    incoming lane
//   lane_ready   block accepts a lane this cycle
//   state_out    assembled state; lane i is at bits [W*i +: W]
//   state_valid  state_out is complete and stable
//   state_ack    consumer has taken state_out
//   ready        block is idle and will accept start
//
// Configuration:
//   LANE_BITREV_EN  when defined, each lane is stored bit-reversed
//                   (lane_data bit j lands in slot bit W-1-j).
// ---------------------------------------------------------------------------
module lane_collector #(
  parameter int W     = 64,
  parameter int LANES = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               lane_valid,
  input  logic [W-1:0]       lane_data,
  output logic               lane_ready,
  output logic [W*LANES-1:0] state_out,
  output logic               state_valid,
  input  logic               state_ack,
  output logic               ready
);

  // A single-lane configuration still needs a one-bit counter.
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    slot_q [LANES];
  logic [W-1:0]    lane_store;
  logic            transfer;

`ifdef LANE_BITREV_EN
  // Mirror the lane so that its LSB lands in the slot's MSB.
  always_comb begin
    lane_store = '0;
    for (int j = 0; j < W; j++) begin
      lane_store[W-1-j] = lane_data[j];
    end
  end
`else
  assign lane_store = lane_data;
`endif

  // A lane moves only when the source offers one and we are collecting.
  assign transfer = lane_valid && (state_q == COLLECT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    lane_ready  = 1'b0;
    state_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        lane_ready = 1'b1;
        if (lane_valid) begin
          // The counter stops at the last slot rather than wrapping; the
          // next start clears it.
          if (cnt_q == LAST_LANE) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here, so a start coinciding
        // with the ack is dropped.
        state_valid = 1'b1;
        if (state_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each slot loads only when the counter points at it during a transfer,
  // so the state is held stable in DONE and retained in IDLE.
  for (genvar i = 0; i < LANES; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_q[i] <= '0;
      end else if (transfer && (cnt_q == CW'(i))) begin
        slot_q[i] <= lane_store;
      end
    end
    assign state_out[W*i +: W] = slot_q[i];
  end

endmodule

// File: tb/tb_lane_collector.sv
// ---------------------------------------------------------------------------
// tb_lane_collector
//
// Self-checking bench for lane_collector. A behavioural model tracks which
// phase the collector should be in and which value each lane slot should
// hold, derived from the handshake rules; every cycle the DUT outputs are
// compared against it. Directed steps cover the sequential fill, gapped
// valid, back-pressure in DONE, mid-collection reset, start coinciding with
// ack, and bit reversal when LANE_BITREV_EN is defined.
// ---------------------------------------------------------------------------
module tb_lane_collector;

  localparam int W     = 64;
  localparam int LANES = 25;
  localparam int P_IDLE    = 0;
  localparam int P_COLLECT = 1;
  localparam int P_DONE    = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               lane_valid = 1'b0;
  logic [W-1:0]       lane_data = '0;
  logic               state_ack = 1'b0;
  logic               lane_ready;
  logic [W*LANES-1:0] state_out;
  logic               state_valid;
  logic               ready;

  int           testCount = 0;
  int           failCount = 0;
  int           phase;
  int           expCount;
  logic [W-1:0] expSlot [LANES];

  lane_collector #(.W(W), .LANES(LANES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .lane_valid  (lane_valid),
    .lane_data   (lane_data),
    .lane_ready  (lane_ready),
    .state_out   (state_out),
    .state_valid (state_valid),
    .state_ack   (state_ack),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // How a lane should appear once stored.
  function automatic logic [W-1:0] storedForm(input logic [W-1:0] d);
`ifdef LANE_BITREV_EN
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) r[W-1-j] = d[j];
    return r;
`else
    return d;
`endif
  endfunction

  function automatic logic [W*LANES-1:0] expectedState();
    logic [W*LANES-1:0] v;
    for (int i = 0; i < LANES; i++) v[W*i +: W] = expSlot[i];
    return v;
  endfunction

  task automatic modelReset();
    phase    = P_IDLE;
    expCount = 0;
    for (int i = 0; i < LANES; i++) expSlot[i] = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Whole-state comparison; on a miss, report the first lane that differs.
  task automatic checkState(input string tag);
    logic [W*LANES-1:0] e;
    int bad;
    e = expectedState();
    testCount++;
    assert (state_out === e) else begin
      failCount++;
      bad = 0;
      for (int i = LANES - 1; i >= 0; i--) begin
        if (state_out[W*i +: W] !== e[W*i +: W]) bad = i;
      end
      $error("[TB] FAIL %s lane %0d observed=%h expected=%h", tag, bad,
             state_out[W*bad +: W], e[W*bad +: W]);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_ready"}, W'(ready), W'(phase == P_IDLE));
    checkOutput({tag, "_lane_ready"}, W'(lane_ready), W'(phase == P_COLLECT));
    checkOutput({tag, "_state_valid"}, W'(state_valid), W'(phase == P_DONE));
    checkState({tag, "_state_out"});
  endtask

  // Advance the model by the rules for the inputs now applied, clock one
  // edge, then compare everything just after the edge.
  task automatic applyStimulus(input string tag);
    case (phase)
      P_IDLE: begin
        if (start) begin
          expCount = 0;
          phase    = P_COLLECT;
        end
      end
      P_COLLECT: begin
        if (lane_valid) begin
          expSlot[expCount] = storedForm(lane_data);
          expCount++;
          if (expCount == LANES) phase = P_DONE;
        end
      end
      default: begin
        if (state_ack) phase = P_IDLE;
      end
    endcase
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic pulseStart(input string tag);
    start = 1'b1;
    applyStimulus(tag);
    start = 1'b0;
  endtask

  // Feed random lanes at a given offer rate, with stray start pulses that
  // must be ignored, until the model reaches DONE or the budget runs out.
  task automatic collectRandom(input string tag, input int validPct);
    int budget;
    budget = 0;
    while (phase != P_DONE && budget < 500) begin
      lane_valid = ($urandom_range(99) < validPct);
      lane_data  = {$urandom, $urandom};
      start      = ($urandom_range(7) == 0);
      applyStimulus(tag);
      budget++;
    end
    lane_valid = 1'b0;
    start      = 1'b0;
    if (phase != P_DONE) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL %s_timeout observed=no DONE expected=DONE", tag);
    end
  endtask

  task automatic ackState(input string tag);
    state_ack = 1'b1;
    applyStimulus(tag);
    state_ack = 1'b0;
  endtask

  initial begin
    modelReset();

    // Reset state.
    #3;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b1;

    // Sequential fill: lane i carries value i, one lane per cycle.
    pulseStart("seq_start");
    for (int i = 0; i < LANES; i++) begin
      lane_valid = 1'b1;
      lane_data  = W'(i);
      applyStimulus("seq_lane");
    end
    lane_valid = 1'b0;
    for (int i = 0; i < LANES; i += 6) begin
      checkOutput("seq_slot", state_out[W*i +: W], storedForm(W'(i)));
    end

    // Back-pressure in DONE: lanes offered but refused, state held.
    lane_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lane_data = {$urandom, $urandom};
      applyStimulus("done_hold");
    end
    lane_valid = 1'b0;
    ackState("done_ack");
    applyStimulus("idle_retain");

    // Alternating valid during collection.
    pulseStart("toggle_start");
    for (int i = 0; i < 2 * LANES; i++) begin
      lane_valid = (i % 2 == 0);
      lane_data  = {$urandom, $urandom};
      applyStimulus("toggle_lane");
    end
    lane_valid = 1'b0;
    checkOutput("toggle_done", W'(state_valid), W'(1));
    ackState("toggle_ack");

    // Random offer rates with stray start pulses.
    for (int r = 0; r < 3; r++) begin
      pulseStart("rand_start");
      collectRandom("rand_lane", 30 + 30 * r);
      for (int k = 0; k < int'($urandom_range(3)); k++) applyStimulus("rand_wait");
      ackState("rand_ack");
    end

    // Reset part way through collection, then an all-ones state.
    pulseStart("rst_start");
    for (int i = 0; i < 12; i++) begin
      lane_valid = 1'b1;
      lane_data  = {$urandom, $urandom};
      applyStimulus("rst_lane");
    end
    lane_valid = 1'b0;
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkAll("rst_async");
    @(negedge clk);
    rst = 1'b1;
    pulseStart("ones_start");
    for (int i = 0; i < LANES; i++) begin
      lane_valid = 1'b1;
      lane_data  = '1;
      applyStimulus("ones_lane");
    end
    lane_valid = 1'b0;
    checkOutput("ones_lo", state_out[W-1:0], '1);
    checkOutput("ones_hi", state_out[W*LANES-1 -: W], '1);

    // start together with ack in DONE returns to IDLE only.
    start     = 1'b1;
    state_ack = 1'b1;
    applyStimulus("start_ack");
    start     = 1'b0;
    state_ack = 1'b0;
    lane_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lane_data = {$urandom, $urandom};
      applyStimulus("idle_ignore");
    end
    lane_valid = 1'b0;

    // Second start collects; lane 0 = 1 shows the storage orientation.
    pulseStart("second_start");
    lane_valid = 1'b1;
    lane_data  = 64'h0000_0000_0000_0001;
    applyStimulus("second_lane0");
    collectRandom("second_lane", 70);
`ifdef LANE_BITREV_EN
    checkOutput("bitrev_slot0", state_out[W-1:0], 64'h8000_0000_0000_0000);
`else
    checkOutput("plain_slot0", state_out[W-1:0], 64'h0000_0000_0000_0001);
`endif
    ackState("second_ack");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
